// File: rtl/stacked_controller.sv
// Backtracking controller for the 8-queens stacked datapath: walks the column
// stack row by row, checks each new queen against the placed rows, counts solutions.
module stacked_controller #(
  parameter logic        FIND_ALL = 1'b0,
  parameter int unsigned CNT_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cout,
  input  logic             down_counter_zero,
  input  logic             last_column,
  input  logic             safe,
  input  logic             stack_ready,
  input  logic             underflow,
  output logic             enable_output,
  output logic             register_load,
  output logic             count,
  output logic             load_counter,
  output logic             push,
  output logic             pop,
  output logic             increament_row,
  output logic             increament_column,
  output logic             ready,
  output logic             done,
  output logic [CNT_W-1:0] solution_count
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT      = 4'd1;
  localparam logic [3:0] S_WAIT      = 4'd2;
  localparam logic [3:0] S_LOAD      = 4'd3;
  localparam logic [3:0] S_CHECK     = 4'd4;
  localparam logic [3:0] S_PLACE     = 4'd5;
  localparam logic [3:0] S_ADVANCE   = 4'd6;
  localparam logic [3:0] S_BACKTRACK = 4'd7;
  localparam logic [3:0] S_WAIT_BT   = 4'd8;
  localparam logic [3:0] S_FOUND     = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  logic [3:0]       state, state_nxt;
  logic [2:0]       depth, depth_nxt;
  logic [CNT_W-1:0] count_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      depth          <= '0;
      solution_count <= '0;
    end else begin
      state          <= state_nxt;
      depth          <= depth_nxt;
      solution_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    depth_nxt         = depth;
    count_nxt         = solution_count;
    enable_output     = 1'b0;
    register_load     = 1'b0;
    count             = 1'b0;
    load_counter      = 1'b0;
    push              = 1'b0;
    pop               = 1'b0;
    increament_row    = 1'b0;
    increament_column = 1'b0;
    ready             = (state == S_IDLE) || (state == S_DONE);
    done              = (state == S_DONE);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_nxt = '0;
          state_nxt = S_INIT;
        end
      end

      // A plain push with no increment seeds the stack with (0,0).
      S_INIT: begin
        push      = 1'b1;
        depth_nxt = '0;
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (stack_ready) state_nxt = S_LOAD;
      end

      S_LOAD: begin
        if (underflow) begin
          state_nxt = S_DONE;
        end else if (depth == 3'd0) begin
          state_nxt = S_PLACE;
        end else begin
          load_counter = 1'b1;
          state_nxt    = S_CHECK;
        end
      end

      // Walk the counter down through every placed row until a conflict or row 0.
      S_CHECK: begin
        if (underflow) begin
          state_nxt = S_DONE;
        end else if (!safe) begin
          state_nxt = S_ADVANCE;
        end else if (down_counter_zero) begin
          state_nxt = S_PLACE;
        end else begin
          count = 1'b1;
        end
      end

      S_PLACE: begin
        register_load = 1'b1;
        if (depth == 3'd7) begin
          state_nxt = S_FOUND;
        end else begin
          push           = 1'b1;
          increament_row = 1'b1;
          depth_nxt      = depth + 3'd1;
          state_nxt      = S_WAIT;
        end
      end

      // A column carry is never expected here; it is handled like the last column.
      S_ADVANCE: begin
        if (underflow) begin
          state_nxt = S_DONE;
        end else if (last_column || cout) begin
          state_nxt = S_BACKTRACK;
        end else begin
          push              = 1'b1;
          pop               = 1'b1;
          increament_column = 1'b1;
          state_nxt         = S_WAIT;
        end
      end

      S_BACKTRACK: begin
        if (depth == 3'd0) begin
          state_nxt = S_DONE;
        end else begin
          pop       = 1'b1;
          depth_nxt = depth - 3'd1;
          state_nxt = S_WAIT_BT;
        end
      end

      S_WAIT_BT: begin
        if (stack_ready) state_nxt = S_ADVANCE;
      end

      S_FOUND: begin
        enable_output = 1'b1;
        if (solution_count != '1) count_nxt = solution_count + CNT_W'(1);
        state_nxt = FIND_ALL ? S_ADVANCE : S_DONE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stacked_controller.sv
// Bench for stacked_controller: two instances (first-solution and find-all) each
// driven by a behavioural stack/board datapath, checked against an enumerated 8-queens list.
module tb_stacked_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n [2];
  logic       start   [2];
  logic       cout    [2];
  logic       dcz     [2];
  logic       last_col[2];
  logic       safe    [2];
  logic       sready  [2];
  logic       uflow   [2];
  logic       en_out  [2];
  logic       reg_load[2];
  logic       cnt_s   [2];
  logic       load_cnt[2];
  logic       push    [2];
  logic       pop     [2];
  logic       inc_row [2];
  logic       inc_col [2];
  logic       ready   [2];
  logic       done    [2];
  logic [6:0] sol_cnt [2];

  stacked_controller #(.FIND_ALL(1'b0), .CNT_W(7)) u_one (
    .clk(clk), .reset(reset_n[0]), .start(start[0]), .cout(cout[0]),
    .down_counter_zero(dcz[0]), .last_column(last_col[0]), .safe(safe[0]),
    .stack_ready(sready[0]), .underflow(uflow[0]), .enable_output(en_out[0]),
    .register_load(reg_load[0]), .count(cnt_s[0]), .load_counter(load_cnt[0]),
    .push(push[0]), .pop(pop[0]), .increament_row(inc_row[0]),
    .increament_column(inc_col[0]), .ready(ready[0]), .done(done[0]),
    .solution_count(sol_cnt[0])
  );

  stacked_controller #(.FIND_ALL(1'b1), .CNT_W(7)) u_all (
    .clk(clk), .reset(reset_n[1]), .start(start[1]), .cout(cout[1]),
    .down_counter_zero(dcz[1]), .last_column(last_col[1]), .safe(safe[1]),
    .stack_ready(sready[1]), .underflow(uflow[1]), .enable_output(en_out[1]),
    .register_load(reg_load[1]), .count(cnt_s[1]), .load_counter(load_cnt[1]),
    .push(push[1]), .pop(pop[1]), .increament_row(inc_row[1]),
    .increament_column(inc_col[1]), .ready(ready[1]), .done(done[1]),
    .solution_count(sol_cnt[1])
  );

  int total = 0;
  int bad   = 0;

  // Datapath environment state
  int stk_row[2][8];
  int stk_col[2][8];
  int sp     [2];
  int busy   [2];
  int board  [2][8];
  int ctr    [2];
  int top_i  [2];
  int top_r  [2];
  int top_c  [2];
  bit force_unsafe[2];
  bit force_uf    [2];
  bit rand_lat    [2];
  bit hold_req    [2];
  bit hold_used   [2];

  // Expectation state
  int mcnt    [2];
  bit acc_prev[2];
  int sols[92][8];
  int nsol;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit queen_ok(input int r, input int c, input int orow, input int ocol);
    int d;
    d = (c > ocol) ? c - ocol : ocol - c;
    return (c != ocol) && (d != r - orow);
  endfunction

  function automatic int pack8(input int a[8]);
    int v;
    v = 0;
    for (int r = 0; r < 8; r++) v = v | ((a[r] & 7) << (3 * r));
    return v;
  endfunction

  function automatic int board_code(input int i);
    int v;
    v = 0;
    for (int r = 0; r < 8; r++) v = v | ((board[i][r] & 7) << (3 * r));
    return v;
  endfunction

  function automatic int ref_code(input int k);
    int v;
    v = 0;
    for (int r = 0; r < 8; r++) v = v | ((sols[k][r] & 7) << (3 * r));
    return v;
  endfunction

  function automatic logic any_strb(input int i);
    return en_out[i] | reg_load[i] | cnt_s[i] | load_cnt[i] |
           push[i] | pop[i] | inc_row[i] | inc_col[i];
  endfunction

  // Lexicographic enumeration of all 8-queens boards.
  task automatic gen_ref();
    int q[8];
    int r;
    bit ok;
    nsol = 0;
    r    = 0;
    for (int k = 0; k < 8; k++) q[k] = 0;
    while (r >= 0) begin
      if (q[r] > 7) begin
        r--;
        if (r >= 0) q[r]++;
      end else begin
        ok = 1'b1;
        for (int j = 0; j < r; j++) if (!queen_ok(r, q[r], j, q[j])) ok = 1'b0;
        if (!ok) begin
          q[r]++;
        end else if (r == 7) begin
          if (nsol < 92) for (int k = 0; k < 8; k++) sols[nsol][k] = q[k];
          nsol++;
          q[r]++;
        end else begin
          r++;
          q[r] = 0;
        end
      end
    end
  endtask

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      top_i[i]    = (sp[i] > 0) ? sp[i] - 1 : 0;
      top_r[i]    = stk_row[i][top_i[i]];
      top_c[i]    = stk_col[i][top_i[i]];
      sready[i]   = (busy[i] == 0);
      uflow[i]    = (sp[i] == 0) || force_uf[i];
      last_col[i] = (top_c[i] == 7);
      cout[i]     = 1'b0;
      dcz[i]      = (ctr[i] == 0);
      safe[i]     = !force_unsafe[i] &&
                    queen_ok(top_r[i], top_c[i], ctr[i], board[i][ctr[i] & 7]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n[i]) begin
        sp[i]   <= 0;
        busy[i] <= 0;
        ctr[i]  <= 0;
      end else begin
        if (reg_load[i]) board[i][top_r[i] & 7] <= top_c[i];
        if (load_cnt[i]) ctr[i] <= top_r[i] - 1;
        else if (cnt_s[i]) ctr[i] <= ctr[i] - 1;
        if (push[i] || pop[i]) begin
          if (hold_req[i] && !hold_used[i]) begin
            busy[i]      <= 10;
            hold_used[i] <= 1'b1;
          end else if (rand_lat[i]) begin
            busy[i] <= int'($urandom_range(2, 0));
          end else begin
            busy[i] <= 2;
          end
          if (push[i] && pop[i]) begin
            stk_col[i][top_i[i]] <= top_c[i] + 1;
          end else if (push[i] && inc_row[i]) begin
            if (sp[i] < 8) begin
              stk_row[i][sp[i]] <= top_r[i] + 1;
              stk_col[i][sp[i]] <= 0;
              sp[i]             <= sp[i] + 1;
            end
          end else if (push[i]) begin
            stk_row[i][0] <= 0;
            stk_col[i][0] <= 0;
            sp[i]         <= 1;
          end else if (sp[i] > 0) begin
            sp[i] <= sp[i] - 1;
          end
        end else if (busy[i] > 0) begin
          busy[i] <= busy[i] - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n[i]) begin
        mcnt[i]     <= 0;
        acc_prev[i] <= 1'b0;
      end else begin
        acc_prev[i] <= ready[i] && start[i];
        if (ready[i] && start[i]) mcnt[i] <= 0;
        else if (en_out[i] && mcnt[i] < 127) mcnt[i] <= mcnt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_count", i), sol_cnt[i], mcnt[i]);
      check($sformatf("u%0d_init_push", i),
            push[i] && !pop[i] && !inc_row[i] && !inc_col[i], acc_prev[i]);
      if (!sready[i] || done[i]) check($sformatf("u%0d_quiet", i), any_strb(i), 0);
      if (done[i]) check($sformatf("u%0d_done_ready", i), ready[i], 1);
      if (!reset_n[i])
        check($sformatf("u%0d_rst_state", i), {ready[i], done[i], any_strb(i)}, 3'b100);
      if (en_out[i] && mcnt[i] < 92)
        check($sformatf("u%0d_board_%0d", i, mcnt[i]), board_code(i), ref_code(mcnt[i]));
    end
  end

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string name);
    int n;
    n = 0;
    while (!done[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, done[i], 1);
  endtask

  task automatic reset_mid(input int i);
    @(negedge clk);
    #1 reset_n[i] = 1'b0;
    #1 check($sformatf("u%0d_async_rst", i),
             {ready[i], done[i], any_strb(i), sol_cnt[i]}, {3'b100, 7'd0});
    repeat (2) @(negedge clk);
    #1 reset_n[i] = 1'b1;
  endtask

  task automatic run_one();
    int quiet;
    int n;
    int lit[8];
    lit = '{0, 4, 7, 5, 2, 6, 1, 3};
    hold_req[0] = 1'b1;
    pulse_start(0);
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!sready[0] && !any_strb(0)) quiet++;
    end
    check("hold_quiet_cycles", quiet, 10);
    n = 0;
    while (!reg_load[0] && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("hold_resume", reg_load[0], 1);
    repeat (50) @(negedge clk);
    check("busy_not_ready", ready[0], 0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 20000, "one_done");
    check("one_board", board_code(0), pack8(lit));
    check("one_count", sol_cnt[0], 1);
    repeat (5) @(negedge clk);
    check("one_hold_done", {done[0], sol_cnt[0]}, {1'b1, 7'd1});
    check("one_pulses", mcnt[0], 1);

    pulse_start(0);
    check("one_restart_clear", sol_cnt[0], 0);
    n = 0;
    while (!cnt_s[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("one_reach_check", cnt_s[0], 1);
    #1 reset_n[0] = 1'b0;
    #1 check("one_rst_in_check", {ready[0], done[0], any_strb(0), sol_cnt[0]}, {3'b100, 7'd0});
    repeat (2) @(negedge clk);
    #1 reset_n[0] = 1'b1;
    pulse_start(0);
    wait_done(0, 20000, "one_rerun_done");
    check("one_rerun_board", board_code(0), pack8(lit));
    check("one_rerun_count", sol_cnt[0], 1);
  endtask

  task automatic run_all();
    int n;
    rand_lat[1] = 1'b1;
    pulse_start(1);
    n = 0;
    while (mcnt[1] < 4 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("all_progress", (mcnt[1] >= 4), 1);
    force_uf[1] = 1'b1;
    wait_done(1, 40, "all_uflow_done");
    check("all_uflow_keep", sol_cnt[1], 4);
    force_uf[1] = 1'b0;

    pulse_start(1);
    check("all_restart_clear", sol_cnt[1], 0);
    repeat (200) @(negedge clk);
    check("all_running", ready[1], 0);
    reset_mid(1);

    force_unsafe[1] = 1'b1;
    pulse_start(1);
    wait_done(1, 3000, "all_exhaust_done");
    check("all_exhaust_count", sol_cnt[1], 0);
    force_unsafe[1] = 1'b0;
  endtask

  initial begin
    int lit_first[8];
    int lit_last[8];
    int lit_second[8];
    for (int i = 0; i < 2; i++) begin
      reset_n[i] = 1'b0;
      start[i]   = 1'b0;
    end
    lit_first  = '{0, 4, 7, 5, 2, 6, 1, 3};
    lit_second = '{0, 5, 7, 2, 6, 3, 1, 4};
    lit_last   = '{7, 3, 0, 2, 5, 1, 6, 4};
    gen_ref();
    check("ref_total", nsol, 92);
    check("ref_first", ref_code(0), pack8(lit_first));
    check("ref_second", ref_code(1), pack8(lit_second));
    check("ref_last", ref_code(91), pack8(lit_last));

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("u%0d_reset_outputs", i),
            {ready[i], done[i], any_strb(i), sol_cnt[i]}, {3'b100, 7'd0});
    #1;
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;

    fork
      run_one();
      run_all();
    join

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
